ihadamard4x4: RTL and testbench
===============================

Name: ihadamard4x4

Overview:
Inverse 4x4 Hadamard engine for the decode/reconstruction side of the FME/transform path. It is the counterpart of the forward Hadamard SATD unit.
- Input: one 4-coefficient row per cycle.
- Internal: row 1-D butterfly, then a ping-pong transpose buffer, then column transform.
- Output: one reconstructed row per cycle, rounded and saturated, so the downstream residual/reconstruction adder consumes it.
- Sustains 1 row/cycle with block overlap.

Parameters:
IN_W, 16, signed input coefficient width
OUT_W, 16, signed output sample width (saturated)
OUT_SHIFT, 1, arithmetic right shift applied after the column pass; 0 means no shift and no rounding add

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  in_row valid
in_ready  out  1  block can accept a row this cycle
in_row  in  4*IN_W  signed coefficients x0..x3, x0 in LSBs
out_valid  out  1  out_row valid
out_ready  in  1  downstream accepts out_row
out_row  out  4*OUT_W  signed results y0..y3, y0 in LSBs
out_row_idx  out  2  row index 0..3 within current block
out_last  out  1  high with out_row_idx==3 while out_valid

Behaviour:
- Handshakes:
  - Transfer occurs on a clk rising edge with valid&ready.
  - Input rows are implicit rows 0..3 of a block; no framing input.
  - valid must not depend on ready.
- 1-D butterfly (shared by both passes):
  - s0=x0+x1, s1=x2+x3, d0=x0-x1, d1=x2-x3.
  - y0=s0+s1, y1=s0-s1, y2=d0-d1, y3=d0+d1.
- Widths: full precision throughout.
  - Row pass output is IN_W+2 signed.
  - Column pass output is IN_W+4 signed.
  - No intermediate truncation.
- Row pass: combinational on in_row. The result is written into the write bank at row wr_cnt on the input transfer.
- Buffer: two banks of 4x4 words (IN_W+2), with per-bank state EMPTY/FILLING/FULL.
  - wr_bank toggles when the 4th row is written; that bank becomes FULL.
  - rd_bank toggles when the last output row is accepted; that bank becomes EMPTY.
- in_ready = write bank not FULL.
- out_valid = read bank FULL.
- Column pass: out_row for index r is the butterfly applied across the 4 stored rows, per column c, selecting output r.
  - This is combinational from the read bank and rd_cnt.
  - out_row_idx = rd_cnt.
- Post-scale: v = (y + (1<<(OUT_SHIFT-1))) >>> OUT_SHIFT, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: if the 4th input row is accepted at edge N, out_valid is high after edge N (first output row visible in the following cycle).
- Throughput:
  - Steady state with out_ready=1: 4 rows in, 4 rows out, no bubbles.
  - Filling one bank while draining the other is legal in the same cycle.
- Boundary conditions:
  - Both banks FULL: in_ready=0 and in_valid is ignored.
  - Output stall (out_ready=0): out_row, idx and last hold stable.
  - Last read of bank A and last write of bank B on the same edge: both state updates apply; bank A becomes EMPTY and bank B becomes FULL.
  - wr_cnt and rd_cnt are 2-bit and wrap 3->0 on bank toggle.
  - Reset mid-block discards all partial and full blocks.
- Reset values: banks EMPTY, wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, out_valid=0, out_row_idx=0, out_last=0, in_ready=1 (after reset), buffer contents don't-care.

Decomposition:
- Shared package fme_pkg: IN_W/OUT_W defaults, bank-state enum {EMPTY, FILLING, FULL}, and a saturate/round function.
- Sub-module hadamard4_1d: combinational parameterised-width butterfly, instantiated once for the row pass and 4 times (one per column) for the column pass.

Test Plan:
- Single block, OUT_SHIFT=1, X[0][0]=4, all other coefficients 0 -> 4 output rows, every sample 2; out_last on row 3; out_valid the cycle after the 4th input transfer.
- Single block, all coefficients 1 -> row0 = [8,0,0,0], rows 1..3 all 0.
- Rounding and saturation:
  - Single coefficient X[0][0]=-3, others 0 -> all 16 outputs -1.
  - All coefficients 32767 -> y[0][0] saturates to 32767.
  - All coefficients -32768 -> y[0][0] saturates to -32768.
- Back-to-back 3 blocks, in_valid=1 and out_ready=1 constantly -> in_ready never drops after the first block; 12 output rows contiguous; idx sequence 0,1,2,3 repeating.
- Backpressure: out_ready=0 for 10 cycles while feeding -> in_ready drops after 8 accepted rows; outputs held stable; on release, data order and values are unchanged versus the golden model.
- Reset asserted after 2 input rows and again mid-output -> out_valid=0 and in_ready=1 immediately; the next full block produces correct results with idx starting at 0.

Source files
------------

// File: rtl/fme_pkg.sv
// ---------------------------------------------------------------------------
// fme_pkg
//   Shared definitions for the FME / transform path.
//   - IN_W_DEF / OUT_W_DEF : default coefficient and sample widths
//   - bank_state_t         : occupancy state of one transpose-buffer bank
//   - round_sat()          : rounding right shift followed by saturation
// ---------------------------------------------------------------------------
package fme_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 16;

    // Working width of round_sat(); wide enough for any IN_W+4 column result
    // of practical size, so callers sign-extend into it and truncate back.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // v = (y + 2^(shift-1)) >>> shift, then clamp to a signed out_w range.
    // shift == 0 passes y through with no rounding offset.
    function automatic logic signed [SAT_W-1:0] round_sat(
        input logic signed [SAT_W-1:0] y,
        input int                      shift,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] v;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        v = y;
        if (shift > 0) begin
            v = (y + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/hadamard4_1d.sv
// ---------------------------------------------------------------------------
// hadamard4_1d
//   Combinational 4-point Hadamard butterfly, full precision.
//     s0 = x0 + x1, s1 = x2 + x3, d0 = x0 - x1, d1 = x2 - x3
//     y0 = s0 + s1, y1 = s0 - s1, y2 = d0 - d1, y3 = d0 + d1
//   Ports
//     x : 4 signed W-bit inputs, x0 in the LSBs
//     y : 4 signed (W+2)-bit outputs, y0 in the LSBs
// ---------------------------------------------------------------------------
module hadamard4_1d #(
    parameter int W = 16
) (
    input  logic [4*W-1:0]     x,
    output logic [4*(W+2)-1:0] y
);

    localparam int OW = W + 2;

    // Sign-extend once up front; W+2 bits hold any sum of four W-bit values,
    // so no intermediate stage can overflow.
    logic signed [OW-1:0] xe [4];
    logic signed [OW-1:0] s0, s1, d0, d1;
    logic signed [OW-1:0] y0, y1, y2, y3;

    for (genvar i = 0; i < 4; i++) begin : g_ext
        assign xe[i] = {{2{x[i*W+W-1]}}, x[i*W +: W]};
    end

    assign s0 = xe[0] + xe[1];
    assign s1 = xe[2] + xe[3];
    assign d0 = xe[0] - xe[1];
    assign d1 = xe[2] - xe[3];

    assign y0 = s0 + s1;
    assign y1 = s0 - s1;
    assign y2 = d0 - d1;
    assign y3 = d0 + d1;

    assign y = {y3, y2, y1, y0};

endmodule

// File: rtl/ihadamard4x4.sv
// ---------------------------------------------------------------------------
// ihadamard4x4
//   Inverse 4x4 Hadamard engine. Rows enter one per cycle, get a row
//   butterfly, and land in a ping-pong transpose buffer. Once a bank holds a
//   full block, the column butterfly runs combinationally out of that bank
//   and one rounded/saturated output row is presented per cycle while the
//   other bank fills.
//
//   Handshake (both sides): a row moves on a rising clk edge where valid and
//   ready are both high; valid never depends on ready, and a presented row
//   (data, idx, last) stays stable until it is accepted.
//
//   Ports
//     clk, rst     : clock, asynchronous active-low reset
//     in_valid     : in_row valid
//     in_ready     : write bank can take a row
//     in_row       : signed coefficients x0..x3 (IN_W each), x0 in LSBs
//     out_valid    : read bank holds a complete block
//     out_ready    : downstream accepts out_row
//     out_row      : signed samples y0..y3 (OUT_W each), y0 in LSBs
//     out_row_idx  : row index 0..3 within the block being drained
//     out_last     : high with out_row_idx == 3 while out_valid
// ---------------------------------------------------------------------------
module ihadamard4x4
    import fme_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int OUT_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*IN_W-1:0]  in_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*OUT_W-1:0] out_row,
    output logic [1:0]         out_row_idx,
    output logic               out_last
);

    localparam int RW = IN_W + 2;   // row-pass word width
    localparam int CW = IN_W + 4;   // column-pass word width

    // ------------------------------------------------------------------
    // Buffer control state
    // ------------------------------------------------------------------
    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wr_bank, wr_bank_d;
    logic        rd_bank, rd_bank_d;
    logic [1:0]  wr_cnt,  wr_cnt_d;
    logic [1:0]  rd_cnt,  rd_cnt_d;

    logic        in_fire;
    logic        out_fire;

    // Storage: [bank][row] -> four RW-bit words, column 0 in LSBs.
    logic [4*RW-1:0] mem_q [2][4];

    logic [4*RW-1:0] row_t;

    // ------------------------------------------------------------------
    // Row pass
    // ------------------------------------------------------------------
    hadamard4_1d #(
        .W (IN_W)
    ) u_row (
        .x (in_row),
        .y (row_t)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= 2'd0;
            rd_cnt    <= 2'd0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank   <= wr_bank_d;
            rd_bank   <= rd_bank_d;
            wr_cnt    <= wr_cnt_d;
            rd_cnt    <= rd_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // The read-side update is applied first and the write-side second.
    // They never target the same bank on one edge: a write needs a
    // non-FULL bank and a read needs a FULL one. So a drain-complete on one
    // bank and a fill-complete on the other both take effect together.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank;
        rd_bank_d = rd_bank;
        wr_cnt_d  = wr_cnt;
        rd_cnt_d  = rd_cnt;

        if (out_fire) begin
            if (rd_cnt == 2'd3) begin
                bank_d[rd_bank] = EMPTY;
                rd_bank_d       = ~rd_bank;
            end
            rd_cnt_d = rd_cnt + 2'd1;
        end

        if (in_fire) begin
            if (wr_cnt == 2'd3) begin
                bank_d[wr_bank] = FULL;
                wr_bank_d       = ~wr_bank;
            end else begin
                bank_d[wr_bank] = FILLING;
            end
            wr_cnt_d = wr_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (handshake flags, row index)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = (bank_q[wr_bank] != FULL);
        out_valid   = (bank_q[rd_bank] == FULL);
        out_row_idx = rd_cnt;
        out_last    = out_valid && (rd_cnt == 2'd3);
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
    end

    // ------------------------------------------------------------------
    // Transpose buffer write (contents need no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wr_bank][wr_cnt] <= row_t;
        end
    end

    // ------------------------------------------------------------------
    // Column pass + post-scale
    // ------------------------------------------------------------------
    // Each column c gathers word c of the four stored rows and runs its own
    // butterfly; rd_cnt selects which butterfly output forms this out_row.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [4*RW-1:0]      col_x;
        logic [4*CW-1:0]      col_y;
        logic signed [CW-1:0] col_sel;

        assign col_x = {mem_q[rd_bank][3][c*RW +: RW],
                        mem_q[rd_bank][2][c*RW +: RW],
                        mem_q[rd_bank][1][c*RW +: RW],
                        mem_q[rd_bank][0][c*RW +: RW]};

        hadamard4_1d #(
            .W (RW)
        ) u_col (
            .x (col_x),
            .y (col_y)
        );

        assign col_sel = col_y[rd_cnt*CW +: CW];

        // round_sat clamps into the OUT_W range, so the truncation below
        // only drops redundant sign bits.
        assign out_row[c*OUT_W +: OUT_W] =
            OUT_W'(round_sat(SAT_W'(col_sel), OUT_SHIFT, OUT_W));
    end

endmodule

// File: tb/tb_ihadamard4x4.sv
// ---------------------------------------------------------------------------
// tb_ihadamard4x4
//   Scoreboard bench for ihadamard4x4. Each generated 4x4 block is turned
//   into its expected 4 output rows by a plain matrix model
//   (Y = H * X * H^T, round, saturate) and pushed into exp_q; a negedge
//   monitor pops and compares whenever an output row is accepted.
// ---------------------------------------------------------------------------
module tb_ihadamard4x4;

    localparam int IN_W      = 16;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 1;

    // ---------------- clock / reset / DUT ----------------
    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [4*IN_W-1:0]  in_row;
    logic               out_valid;
    logic               out_ready;
    logic [4*OUT_W-1:0] out_row;
    logic [1:0]         out_row_idx;
    logic               out_last;

    ihadamard4x4 #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [4*OUT_W-1:0] exp_q[$];
    logic [1:0]         exp_idx_q[$];
    logic [4*IN_W-1:0]  in_q[$];
    int                 pop_cyc_q[$];

    int blk [4][4];
    int hmat [4][4] = '{'{1,  1,  1,  1},
                        '{1,  1, -1, -1},
                        '{1, -1, -1,  1},
                        '{1, -1,  1, -1}};

    int out_mode  = 1;   // 0: out_ready low, 1: high, 2: random
    int stall_cnt = 0;

    bit                 stall_pend = 0;
    logic [4*OUT_W-1:0] held_row;
    logic [1:0]         held_idx;
    logic               held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint scale_sat(input longint y);
        longint v;
        longint hi;
        longint lo;
        v  = y;
        if (OUT_SHIFT > 0) v = (y + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    // Queue the input rows of blk and the expected output rows.
    task automatic push_block();
        logic [4*IN_W-1:0]  r;
        logic [4*OUT_W-1:0] o;
        longint             y;
        longint             v;
        int                 t;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                t = blk[i][j];
                r[j*IN_W +: IN_W] = t[IN_W-1:0];
            end
            in_q.push_back(r);
        end
        for (int rr = 0; rr < 4; rr++) begin
            for (int c = 0; c < 4; c++) begin
                y = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        y += longint'(hmat[rr][i] * hmat[c][j]) * longint'(blk[i][j]);
                v = scale_sat(y);
                o[c*OUT_W +: OUT_W] = v[OUT_W-1:0];
            end
            exp_q.push_back(o);
            exp_idx_q.push_back(2'(rr));
        end
    endtask

    task automatic gen_const(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                blk[i][j] = v;
        push_block();
    endtask

    task automatic gen_single(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                blk[i][j] = 0;
        blk[0][0] = v;
        push_block();
    endtask

    task automatic gen_rand();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                blk[i][j] = int'($urandom_range(0, 65535)) - 32768;
        push_block();
    endtask

    // ---------------- drivers (act at posedge + 1) ----------------
    always @(posedge clk) begin
        #1;
        case (out_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_row(input logic [4*IN_W-1:0] r);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_row   = r;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            stall_cnt++;
        end
        check("send_row_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int max_gap);
        logic [4*IN_W-1:0] r;
        while (in_q.size() > 0) begin
            r = in_q.pop_front();
            send_row(r);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        if (exp_q.size() == 0) check("idle_after_drain", 64'(out_valid), 64'(0));
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_idx",       64'(out_row_idx), 64'(0));
        check("rst_last",      64'(out_last),  64'(0));
        exp_q.delete();
        exp_idx_q.delete();
        in_q.delete();
        stall_pend = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (stall_pend) begin
                check("stall_valid", 64'(out_valid),   64'(1));
                check("stall_row",   64'(out_row),     64'(held_row));
                check("stall_idx",   64'(out_row_idx), 64'(held_idx));
                check("stall_last",  64'(out_last),    64'(held_last));
                stall_pend = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0h required=none (t=%0t)", out_row, $time);
                end else begin
                    logic [4*OUT_W-1:0] e;
                    logic [1:0]         ei;
                    e  = exp_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    check("out_row",  64'(out_row),     64'(e));
                    check("out_idx",  64'(out_row_idx), 64'(ei));
                    check("out_last", 64'(out_last),    64'(ei == 2'd3));
                    pop_cyc_q.push_back(cyc);
                end
            end else if (out_valid) begin
                held_row   = out_row;
                held_idx   = out_row_idx;
                held_last  = out_last;
                stall_pend = 1;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int accepted;
        int n;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("init_out_valid", 64'(out_valid), 64'(0));
        check("init_in_ready",  64'(in_ready),  64'(1));
        check("init_idx",       64'(out_row_idx), 64'(0));
        check("init_last",      64'(out_last),  64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single DC coefficient: all samples 2, valid right after 4th row.
        out_mode = 1;
        gen_single(4);
        check("pre_latency_valid", 64'(out_valid), 64'(0));
        send_all(0);
        check("latency_valid", 64'(out_valid), 64'(1));
        check("latency_idx",   64'(out_row_idx), 64'(0));
        wait_drain(50);

        // All ones, then rounding and saturation corners.
        gen_const(1);
        send_all(0);
        wait_drain(50);
        gen_single(-3);
        gen_const(32767);
        gen_const(-32768);
        send_all(0);
        wait_drain(100);

        // Back-to-back blocks with no bubbles on either side.
        pop_cyc_q.delete();
        stall_cnt = 0;
        repeat (3) gen_rand();
        send_all(0);
        check("b2b_in_stalls", 64'(stall_cnt), 64'(0));
        wait_drain(100);
        check("b2b_out_rows", 64'(pop_cyc_q.size()), 64'(12));
        if (pop_cyc_q.size() == 12)
            check("b2b_out_span", 64'(pop_cyc_q[11] - pop_cyc_q[0]), 64'(11));

        // Backpressure: both banks fill, input stalls after 8 rows.
        out_mode  = 0;
        out_ready = 1'b0;
        repeat (3) gen_rand();
        accepted = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_row   = in_q[0];
            if (in_ready) begin
                void'(in_q.pop_front());
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted",  64'(accepted),  64'(8));
        check("bp_in_ready",  64'(in_ready),  64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        out_mode  = 1;
        out_ready = 1'b1;
        send_all(0);
        wait_drain(100);

        // Reset after two input rows, then again mid-output.
        gen_rand();
        send_row(in_q.pop_front());
        send_row(in_q.pop_front());
        do_reset();
        gen_rand();
        send_all(0);
        n = 0;
        while (exp_q.size() > 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_out_progress", 64'(exp_q.size()), 64'(2));
        do_reset();
        gen_rand();
        send_all(0);
        wait_drain(50);

        // Random traffic with random gaps and random out_ready.
        out_mode = 2;
        repeat (8) gen_rand();
        send_all(2);
        wait_drain(1000);
        out_mode = 1;

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
